flit_sink: RTL and testbench

FLIT_SINK -- requirements
Module: flit_sink

---
 rtl/flit_sink_if.sv | 37 +++
 rtl/flit_sink.sv | 179 +++++++++++++++++
 tb/tb_flit_sink.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_sink_if.sv
// Flit input bus and packet/statistics outputs of flit_sink.
// master drives flits and clr; slave (the sink) drives the registered results.
interface flit_sink_if #(
    parameter int DATAW = 64,
    parameter int TYPEW = 2,
    parameter int VCHW  = 1,
    parameter int CNTW  = 32
);
    logic [TYPEW+DATAW-1:0] idata;
    logic                   ivalid;
    logic [VCHW-1:0]        ivch;
    logic                   clr;

    logic                   pkt_done;
    logic [VCHW-1:0]        pkt_vch;
    logic [7:0]             pkt_len;
    logic [DATAW-1:0]       pkt_dst;
    logic [CNTW-1:0]        flit_cnt;
    logic [CNTW-1:0]        pkt_cnt;
    logic [CNTW-1:0]        busy_cnt;
    logic [CNTW-1:0]        cyc_cnt;
    logic [CNTW-1:0]        tgl_cnt;
    logic                   err;
    logic [2:0]             err_code;

    modport master (
        output idata, ivalid, ivch, clr,
        input  pkt_done, pkt_vch, pkt_len, pkt_dst,
        input  flit_cnt, pkt_cnt, busy_cnt, cyc_cnt, tgl_cnt, err, err_code
    );

    modport slave (
        input  idata, ivalid, ivch, clr,
        output pkt_done, pkt_vch, pkt_len, pkt_dst,
        output flit_cnt, pkt_cnt, busy_cnt, cyc_cnt, tgl_cnt, err, err_code
    );
endinterface

// File: rtl/flit_sink.sv
// Per-VC packet framing checker with saturating statistics; all outputs registered, one cycle after the flit.
// No backpressure: every flit presented with ivalid is consumed in the cycle it is sampled.
module flit_sink #(
    parameter int DATAW  = 64,
    parameter int TYPEW  = 2,
    parameter int VCHW   = 1,
    parameter int MAXLEN = 32,
    parameter int CNTW   = 32
) (
    input  logic         clk,
    input  logic         rst,
    flit_sink_if.slave   bus
);
    localparam int NVC = 2 ** VCHW;

    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } vc_state_t;

    typedef struct packed {
        vc_state_t        st;
        logic [7:0]       cnt;
        logic [DATAW-1:0] head;
    } vc_t;

    vc_t vc_q [NVC];
    vc_t vc_d [NVC];
    vc_t cur;

    logic [TYPEW-1:0] ftype;
    logic [DATAW-1:0] pay;
    logic             is_flit;
    logic             done_d;
    logic             err_hit;
    logic [2:0]       err_val;

    logic [DATAW-1:0] prev_q;
    logic [DATAW-1:0] diff;
    logic [CNTW-1:0]  pc;
    logic [CNTW:0]    tgl_sum;
    logic [CNTW-1:0]  tgl_nxt;

    logic             pkt_done_q;
    logic [VCHW-1:0]  pkt_vch_q;
    logic [7:0]       pkt_len_q;
    logic [DATAW-1:0] pkt_dst_q;
    logic [CNTW-1:0]  flit_cnt_q, pkt_cnt_q, busy_cnt_q, cyc_cnt_q, tgl_cnt_q;
    logic             err_q;
    logic [2:0]       err_code_q;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    assign ftype   = bus.idata[TYPEW+DATAW-1:DATAW];
    assign pay     = bus.idata[DATAW-1:0];
    assign cur     = vc_q[bus.ivch];
    assign is_flit = (ftype == T_HEAD) || (ftype == T_DATA) || (ftype == T_TAIL);

    // Only the addressed VC moves; any type code outside HEAD/DATA/TAIL is treated as NONE.
    always_comb begin
        vc_d    = vc_q;
        done_d  = 1'b0;
        err_hit = 1'b0;
        err_val = 3'd0;
        if (bus.ivalid) begin
            if (ftype == T_HEAD) begin
                if (cur.st == BODY) begin
                    err_hit = 1'b1;
                    err_val = 3'd1;
                end
                vc_d[bus.ivch] = '{st: BODY, cnt: 8'd0, head: pay};
            end else if (ftype == T_DATA) begin
                if (cur.st == IDLE) begin
                    err_hit = 1'b1;
                    err_val = 3'd2;
                end else if (cur.cnt == 8'(MAXLEN)) begin
                    err_hit = 1'b1;
                    err_val = 3'd4;
                    vc_d[bus.ivch].st = IDLE;
                end else begin
                    vc_d[bus.ivch].cnt = cur.cnt + 8'd1;
                end
            end else if (ftype == T_TAIL) begin
                if (cur.st == IDLE) begin
                    err_hit = 1'b1;
                    err_val = 3'd2;
                end else begin
                    vc_d[bus.ivch].st = IDLE;
                    done_d = 1'b1;
                end
            end else begin
                err_hit = 1'b1;
                err_val = 3'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NVC; i++) vc_q[i] <= '0;
        end else begin
            vc_q <= vc_d;
        end
    end

    assign diff = pay ^ prev_q;

    always_comb begin
        pc = '0;
        for (int i = 0; i < DATAW; i++) pc = pc + CNTW'(diff[i]);
        tgl_sum = {1'b0, tgl_cnt_q} + {1'b0, pc};
        tgl_nxt = tgl_sum[CNTW] ? '1 : tgl_sum[CNTW-1:0];
    end

    // Packet path and prev keep running through clr; only statistics and error state are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            pkt_done_q <= 1'b0;
            pkt_vch_q  <= '0;
            pkt_len_q  <= '0;
            pkt_dst_q  <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            busy_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            tgl_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            pkt_done_q <= done_d;
            if (bus.ivalid) prev_q <= pay;
            if (done_d) begin
                pkt_vch_q <= bus.ivch;
                pkt_len_q <= cur.cnt;
                pkt_dst_q <= cur.head;
            end
            if (bus.clr) begin
                flit_cnt_q <= '0;
                pkt_cnt_q  <= '0;
                busy_cnt_q <= '0;
                cyc_cnt_q  <= '0;
                tgl_cnt_q  <= '0;
                err_q      <= 1'b0;
                err_code_q <= 3'd0;
            end else begin
                cyc_cnt_q <= sat_inc(cyc_cnt_q);
                if (bus.ivalid) begin
                    busy_cnt_q <= sat_inc(busy_cnt_q);
                    tgl_cnt_q  <= tgl_nxt;
                end
                if (bus.ivalid && is_flit) flit_cnt_q <= sat_inc(flit_cnt_q);
                if (done_d) pkt_cnt_q <= sat_inc(pkt_cnt_q);
                if (err_hit) begin
                    err_q <= 1'b1;
                    if (!err_q) err_code_q <= err_val;
                end
            end
        end
    end

    assign bus.pkt_done = pkt_done_q;
    assign bus.pkt_vch  = pkt_vch_q;
    assign bus.pkt_len  = pkt_len_q;
    assign bus.pkt_dst  = pkt_dst_q;
    assign bus.flit_cnt = flit_cnt_q;
    assign bus.pkt_cnt  = pkt_cnt_q;
    assign bus.busy_cnt = busy_cnt_q;
    assign bus.cyc_cnt  = cyc_cnt_q;
    assign bus.tgl_cnt  = tgl_cnt_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_flit_sink.sv
// Randomized and directed bench for flit_sink against a packet-level reference model with a scoreboard.
module tb_flit_sink;
    localparam int DW = 64;
    localparam int TW = 2;
    localparam int VW = 1;
    localparam int ML = 32;

    localparam int T_NONE = 0, T_HEAD = 1, T_DATA = 2, T_TAIL = 3;
    localparam int S_PKT = 0, S_FLIT = 1, S_BUSY = 2, S_CYC = 3, S_TGL = 4, S_ERR = 5,
                   S_CODE = 6, S_LEN = 7, S_DST = 8, S_SBQ = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flit_sink_if #(.DATAW(DW), .TYPEW(TW), .VCHW(VW), .CNTW(32)) bus ();
    flit_sink_if #(.DATAW(DW), .TYPEW(TW), .VCHW(VW), .CNTW(8))  bus8 ();

    assign bus8.idata  = bus.idata;
    assign bus8.ivalid = bus.ivalid;
    assign bus8.ivch   = bus.ivch;
    assign bus8.clr    = bus.clr;

    flit_sink #(.DATAW(DW), .TYPEW(TW), .VCHW(VW), .MAXLEN(ML), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    flit_sink #(.DATAW(DW), .TYPEW(TW), .VCHW(VW), .MAXLEN(ML), .CNTW(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    typedef struct packed {
        logic       vch;
        logic [7:0] len;
        logic [63:0] dst;
    } pkt_t;

    typedef struct {
        int          sel;
        logic [63:0] exp;
    } spot_t;

    pkt_t  exp_q [$];
    spot_t spot_q [$];

    int n_err = 0;
    int n_chk = 0;

    // Reference model: packet-level view of each VC plus plain statistics totals since the last clear.
    longint unsigned m_flit = 0, m_pkt = 0, m_busy = 0, m_cyc = 0, m_tgl = 0;
    logic        m_err = 1'b0;
    logic [2:0]  m_code = 3'd0;
    logic [63:0] m_prev = '0;
    logic        m_open [2];
    int          m_len [2];
    logic [63:0] m_dst [2];
    int          mt, mv, me;
    logic [63:0] mp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_flit = 0; m_pkt = 0; m_busy = 0; m_cyc = 0; m_tgl = 0;
            m_err = 1'b0; m_code = 3'd0; m_prev = '0;
            for (int i = 0; i < 2; i++) begin
                m_open[i] = 1'b0; m_len[i] = 0; m_dst[i] = '0;
            end
        end else begin
            m_cyc++;
            if (bus.ivalid) begin
                mt = int'(bus.idata[65:64]);
                mp = bus.idata[63:0];
                mv = int'(bus.ivch);
                me = 0;
                m_busy++;
                if (mt != T_NONE) m_flit++;
                m_tgl += longint'($countones(mp ^ m_prev));
                m_prev = mp;
                case (mt)
                    T_HEAD: begin
                        if (m_open[mv]) me = 1;
                        m_open[mv] = 1'b1; m_len[mv] = 0; m_dst[mv] = mp;
                    end
                    T_DATA: begin
                        if (!m_open[mv]) me = 2;
                        else if (m_len[mv] == ML) begin me = 4; m_open[mv] = 1'b0; end
                        else m_len[mv]++;
                    end
                    T_TAIL: begin
                        if (!m_open[mv]) me = 2;
                        else begin
                            exp_q.push_back('{vch: mv[0], len: 8'(m_len[mv]), dst: m_dst[mv]});
                            m_open[mv] = 1'b0;
                            m_pkt++;
                        end
                    end
                    default: me = 3;
                endcase
                if (me != 0 && !m_err) m_code = 3'(me);
                if (me != 0) m_err = 1'b1;
            end
            if (bus.clr) begin
                m_flit = 0; m_pkt = 0; m_busy = 0; m_cyc = 0; m_tgl = 0;
                m_err = 1'b0; m_code = 3'd0;
            end
        end
    end

    function automatic logic [63:0] sat(input longint unsigned x, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on every pkt_done, then per-cycle statistics and queued spot checks.
    pkt_t  mp_pkt;
    spot_t ms;
    always @(negedge clk) begin
        if (bus.pkt_done) begin
            if (exp_q.size() == 0) begin
                check("pkt_done_unexpected", 64'(bus.pkt_done), 64'd0);
            end else begin
                mp_pkt = exp_q.pop_front();
                check("pkt_vch", 64'(bus.pkt_vch), 64'(mp_pkt.vch));
                check("pkt_len", 64'(bus.pkt_len), 64'(mp_pkt.len));
                check("pkt_dst", bus.pkt_dst, mp_pkt.dst);
            end
        end
        check("pkt_cnt",  64'(bus.pkt_cnt),  sat(m_pkt, 32));
        check("flit_cnt", 64'(bus.flit_cnt), sat(m_flit, 32));
        check("busy_cnt", 64'(bus.busy_cnt), sat(m_busy, 32));
        check("cyc_cnt",  64'(bus.cyc_cnt),  sat(m_cyc, 32));
        check("tgl_cnt",  64'(bus.tgl_cnt),  sat(m_tgl, 32));
        check("err",      64'(bus.err),      64'(m_err));
        check("err_code", 64'(bus.err_code), 64'(m_code));
        check("pkt_cnt8",  64'(bus8.pkt_cnt),  sat(m_pkt, 8));
        check("flit_cnt8", 64'(bus8.flit_cnt), sat(m_flit, 8));
        check("busy_cnt8", 64'(bus8.busy_cnt), sat(m_busy, 8));
        check("cyc_cnt8",  64'(bus8.cyc_cnt),  sat(m_cyc, 8));
        check("tgl_cnt8",  64'(bus8.tgl_cnt),  sat(m_tgl, 8));
        while (spot_q.size() != 0) begin
            ms = spot_q.pop_front();
            case (ms.sel)
                S_PKT:   check("spot_pkt_cnt",  64'(bus.pkt_cnt),  ms.exp);
                S_FLIT:  check("spot_flit_cnt", 64'(bus.flit_cnt), ms.exp);
                S_BUSY:  check("spot_busy_cnt", 64'(bus.busy_cnt), ms.exp);
                S_CYC:   check("spot_cyc_cnt",  64'(bus.cyc_cnt),  ms.exp);
                S_TGL:   check("spot_tgl_cnt",  64'(bus.tgl_cnt),  ms.exp);
                S_ERR:   check("spot_err",      64'(bus.err),      ms.exp);
                S_CODE:  check("spot_err_code", 64'(bus.err_code), ms.exp);
                S_LEN:   check("spot_pkt_len",  64'(bus.pkt_len),  ms.exp);
                S_DST:   check("spot_pkt_dst",  bus.pkt_dst,       ms.exp);
                default: check("spot_sb_pending", 64'(exp_q.size()), ms.exp);
            endcase
        end
    end

    // Spot checks apply to outputs at the end of the next step.
    task automatic expect_next(input int sel, input logic [63:0] v);
        spot_q.push_back('{sel: sel, exp: v});
    endtask

    task automatic step(input logic v, input int t, input int vc, input logic [63:0] pl, input logic c);
        logic [1:0] t2;
        t2 = 2'(t);
        bus.ivalid = v;
        bus.idata  = {t2, pl};
        bus.ivch   = 1'(vc);
        bus.clr    = c;
        @(negedge clk);
        #1;
    endtask

    task automatic flit(input int t, input int vc, input logic [63:0] pl);
        step(1'b1, t, vc, pl, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, T_NONE, 0, '0, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, T_NONE, 0, '0, 1'b1);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int r, t;
        bus.ivalid = 1'b0;
        bus.idata  = '0;
        bus.ivch   = '0;
        bus.clr    = 1'b0;
        rst = 1'b1;
        idle(1);
        expect_next(S_CYC, 64'd0);
        expect_next(S_TGL, 64'd0);
        expect_next(S_ERR, 64'd0);
        expect_next(S_CODE, 64'd0);
        expect_next(S_DST, 64'd0);
        idle(1);
        rst = 1'b0;
        idle(2);

        // Toggle count from reset value of prev
        flit(T_HEAD, 1, 64'h0);
        flit(T_DATA, 1, '1);
        expect_next(S_TGL, 64'd126);
        flit(T_DATA, 1, 64'h3);
        flit(T_TAIL, 1, 64'h3);
        idle(2);

        // Single 20-DATA packet on VC0
        clear();
        flit(T_HEAD, 0, 64'h09);
        for (int i = 0; i < 20; i++) flit(T_DATA, 0, rnd64());
        flit(T_TAIL, 0, rnd64());
        expect_next(S_PKT, 64'd1);
        expect_next(S_FLIT, 64'd22);
        expect_next(S_ERR, 64'd0);
        expect_next(S_LEN, 64'd20);
        expect_next(S_DST, 64'h09);
        idle(1);
        expect_next(S_SBQ, 64'd0);
        idle(1);

        // Ten back-to-back packets with idle gaps
        clear();
        for (int p = 0; p < 10; p++) begin
            flit(T_HEAD, 0, rnd64());
            for (int i = 0; i < 20; i++) flit(T_DATA, 0, rnd64());
            flit(T_TAIL, 0, rnd64());
            if (p < 9) idle(7);
            else begin
                idle(6);
                expect_next(S_BUSY, 64'd220);
                expect_next(S_PKT, 64'd10);
                expect_next(S_CYC, 64'd290);
                idle(1);
            end
        end

        // First error code is kept, clr wipes it
        clear();
        flit(T_DATA, 0, 64'h1);
        flit(T_HEAD, 1, 64'h5);
        expect_next(S_ERR, 64'd1);
        expect_next(S_CODE, 64'd2);
        flit(T_HEAD, 1, 64'h6);
        expect_next(S_ERR, 64'd0);
        expect_next(S_CODE, 64'd0);
        clear();
        flit(T_TAIL, 1, 64'h7);
        idle(2);

        // Interleaved VCs
        clear();
        flit(T_HEAD, 0, 64'hA);
        flit(T_HEAD, 1, 64'hB);
        flit(T_DATA, 0, rnd64());
        flit(T_DATA, 1, rnd64());
        flit(T_DATA, 0, rnd64());
        flit(T_DATA, 1, rnd64());
        flit(T_DATA, 0, rnd64());
        flit(T_DATA, 1, rnd64());
        flit(T_TAIL, 0, rnd64());
        flit(T_DATA, 1, rnd64());
        flit(T_DATA, 1, rnd64());
        expect_next(S_PKT, 64'd2);
        expect_next(S_ERR, 64'd0);
        expect_next(S_LEN, 64'd5);
        flit(T_TAIL, 1, rnd64());
        idle(1);
        expect_next(S_SBQ, 64'd0);
        idle(1);

        // Length overflow
        clear();
        flit(T_HEAD, 0, 64'h11);
        for (int i = 0; i < ML; i++) flit(T_DATA, 0, rnd64());
        expect_next(S_CODE, 64'd4);
        flit(T_DATA, 0, rnd64());
        expect_next(S_CODE, 64'd4);
        flit(T_TAIL, 0, rnd64());
        idle(2);

        // Reset in the middle of a packet
        flit(T_HEAD, 0, 64'h22);
        for (int i = 0; i < 4; i++) flit(T_DATA, 0, rnd64());
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        expect_next(S_CODE, 64'd2);
        flit(T_TAIL, 0, rnd64());
        idle(1);
        expect_next(S_PKT, 64'd0);
        expect_next(S_SBQ, 64'd0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 19);
            t = (r == 0) ? T_NONE : (r < 4) ? T_HEAD : (r < 16) ? T_DATA : T_TAIL;
            step($urandom_range(0, 9) != 0, t, $urandom_range(0, 1), rnd64(),
                 $urandom_range(0, 63) == 0);
        end
        idle(3);
        expect_next(S_SBQ, 64'd0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
